gpio_arbiter: RTL and testbench
===============================

Name: gpio_arbiter

Overview:
Round-robin controller that shares one gpio instance between NREQ requesters. It owns the gpio_dir and gpio_write registers that drive the gpio block. It serialises masked direction/write/read commands and returns one response per command. Read commands wait a settle window covering the gpio block's output and input register stages, so read data reflects prior writes.

Parameters:
length, 4, GPIO pin count; must match the attached gpio instance
NREQ, 2, number of requesters (2..8)
SETTLE, 2, wait cycles before sampling gpio_read on a READ (1..15)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester command valid
req_ready  out  NREQ  per-requester accept; one-hot or zero
req_op  in  2*NREQ  op for requester k at bits [2k+1:2k]: 00 DIR, 01 WRITE, 10 READ, 11 reserved
req_mask  in  length*NREQ  pin mask for requester k at bits [length*k +: length]
req_data  in  length*NREQ  data for requester k, same slicing
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  3  index of the requester being answered
rsp_data  out  length  response data
rsp_err  out  1  reserved op flag, qualified by rsp_valid
busy  out  1  high when the state is not IDLE
gpio_dir  out  length  to gpio.gpio_dir (1 = output)
gpio_write  out  length  to gpio.gpio_write
gpio_read  in  length  from gpio.gpio_read

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, gpio_dir=0 (all pins input), gpio_write=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rr pointer=NREQ-1. req_ready=0 while rst is high.
- Reset mid-operation abandons the command with no response. Register updates already taken are cleared by reset.
- States: IDLE, EXEC, WAIT, RESP.
- IDLE: if any req_valid is set, grant the first valid requester searching upward from pointer+1 modulo NREQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - Latch op, mask and data of the granted requester. Set pointer=g. Go to EXEC.
  - req_ready is 0 in all other states.
- EXEC (one cycle):
  - DIR: gpio_dir <= (gpio_dir & ~mask) | (data & mask). Go to RESP.
  - WRITE: same update applied to gpio_write. Go to RESP.
  - READ: load the settle counter with SETTLE. Go to WAIT.
  - Reserved op: no register change. Go to RESP.
- WAIT: decrement the counter each cycle. In the cycle the counter reaches 1, capture gpio_read & mask at the edge and go to RESP.
- RESP (one cycle): rsp_valid=1, rsp_id=g. Go to IDLE.
  - DIR response: rsp_data = new gpio_dir.
  - WRITE response: rsp_data = new gpio_write.
  - READ response: rsp_data = captured value.
  - Reserved op response: rsp_data=0, rsp_err=1.
  - rsp_err=0 for all other ops. rsp_valid=0 in all other states.
- Latency, with accept in cycle T:
  - DIR/WRITE: gpio_* updated from T+2, rsp_valid in T+2.
  - READ: rsp_valid in T+2+SETTLE.
  - Next accept no earlier than the IDLE cycle after RESP.
- Masks: mask=0 gives no register change, but the response is still issued. Unmasked bits of a READ return 0.
- Fairness: a continuously asserted requester cannot be granted twice while another requester holds req_valid.
- Requesters must hold req_valid and operands stable until req_ready. The block samples them only in the accept cycle.
- busy=1 in EXEC, WAIT and RESP.

Test Plan:
- Reset: pulse rst with commands pending -> gpio_dir=0, gpio_write=0, rsp_valid=0, req_ready=0 during rst; first grant after release goes to req 0.
- Masked DIR then WRITE from req0 (DIR mask=4'hF data=4'hF; WRITE mask=4'b0101 data=4'b1111) -> gpio_dir=4'hF, gpio_write=4'b0101; rsp_data 4'hF then 4'b0101; rsp_valid two cycles after each accept.
- READ loopback through a real gpio instance with SETTLE=2, after writing 4'b1010 to all-output pins -> READ mask=4'hF returns rsp_data=4'b1010 exactly 4 cycles after accept.
- Round-robin: req0 and req1 both valid continuously with WRITE ops -> grants alternate 0,1,0,1; rsp_id matches each grant.
- Reserved op 11 from req1 -> rsp_valid with rsp_err=1, rsp_data=0, rsp_id=1; gpio_dir and gpio_write unchanged.
- Reset asserted during WAIT of a READ -> no rsp_valid, state IDLE next cycle, pending requester re-granted after release.

Source files
------------

// File: rtl/gpio_arbiter.sv
// gpio_arbiter: round-robin front end that shares one gpio block between
// NREQ requesters. Owns the gpio_dir / gpio_write registers and serialises
// masked DIR / WRITE / READ commands, answering each with one response pulse.
//
// Handshake: a requester raises req_valid[k] with op/mask/data stable; the
// arbiter raises req_ready[k] combinationally in the single IDLE cycle it
// grants k, and the command is taken at that clock edge. Afterwards the
// requester may drop or change its request. Exactly one rsp_valid pulse
// follows each accepted command unless rst intervenes.
module gpio_arbiter #(
  parameter int length = 4,
  parameter int NREQ   = 2,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [length*NREQ-1:0]   req_mask,
  input  logic [length*NREQ-1:0]   req_data,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [length-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [length-1:0]        gpio_dir,
  output logic [length-1:0]        gpio_write,
  input  logic [length-1:0]        gpio_read
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_DIR   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  state_t              state;
  logic [2:0]          ptr;
  logic [2:0]          gnt_id;
  logic                any_valid;
  logic [1:0]          sel_op;
  logic [length-1:0]   sel_mask;
  logic [length-1:0]   sel_data;
  logic [1:0]          cur_op;
  logic [length-1:0]   cur_mask;
  logic [length-1:0]   cur_data;
  logic [3:0]          cnt;
  logic [length-1:0]   new_dir;
  logic [length-1:0]   new_write;

  // Round-robin search: first valid requester at or after ptr+1 (mod NREQ).
  always_comb begin
    any_valid = 1'b0;
    gnt_id    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!any_valid && req_valid[k] && ((int'(ptr) + off) % NREQ) == k) begin
          any_valid = 1'b1;
          gnt_id    = 3'(k);
        end
      end
    end
  end

  // Operand mux for the granted requester, plus the one-hot ready strobe.
  always_comb begin
    sel_op    = '0;
    sel_mask  = '0;
    sel_data  = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_id == 3'(k)) begin
        sel_op   = req_op[2*k +: 2];
        sel_mask = req_mask[length*k +: length];
        sel_data = req_data[length*k +: length];
        req_ready[k] = (state == IDLE) && !rst && any_valid;
      end
    end
  end

  assign new_dir   = (gpio_dir   & ~cur_mask) | (cur_data & cur_mask);
  assign new_write = (gpio_write & ~cur_mask) | (cur_data & cur_mask);
  assign busy      = (state != IDLE);

  // Command FSM with registered gpio registers and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 3'(NREQ - 1);
      cur_op     <= '0;
      cur_mask   <= '0;
      cur_data   <= '0;
      cnt        <= '0;
      gpio_dir   <= '0;
      gpio_write <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // Response flags are pulses: only the transition into RESP raises them.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            cur_op   <= sel_op;
            cur_mask <= sel_mask;
            cur_data <= sel_data;
            ptr      <= gnt_id;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cur_op == OP_READ) begin
            cnt   <= 4'(SETTLE);
            state <= WAIT;
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= ptr;
            state     <= RESP;
            if (cur_op == OP_DIR) begin
              gpio_dir <= new_dir;
              rsp_data <= new_dir;
            end else if (cur_op == OP_WRITE) begin
              gpio_write <= new_write;
              rsp_data   <= new_write;
            end else begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        WAIT: begin
          // Sample on the last settle cycle so the gpio pipeline has caught up.
          if (cnt == 4'd1) begin
            rsp_data  <= gpio_read & cur_mask;
            rsp_valid <= 1'b1;
            rsp_id    <= ptr;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// tb_gpio_arbiter: table-driven and randomized checks of gpio_arbiter
// against a per-bit behavioural model, with a two-stage gpio loopback.
module tb_gpio_arbiter;
  localparam int L      = 4;
  localparam int NREQ   = 2;
  localparam int SETTLE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [L*NREQ-1:0]  req_mask;
  logic [L*NREQ-1:0]  req_data;
  logic               rsp_valid;
  logic [2:0]         rsp_id;
  logic [L-1:0]       rsp_data;
  logic               rsp_err;
  logic               busy;
  logic [L-1:0]       gpio_dir;
  logic [L-1:0]       gpio_write;
  logic [L-1:0]       gpio_read;

  gpio_arbiter #(.length(L), .NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mask(req_mask), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy),
    .gpio_dir(gpio_dir), .gpio_write(gpio_write), .gpio_read(gpio_read)
  );

  // gpio stand-in: output register stage then input register stage.
  logic [L-1:0] ext;
  logic [L-1:0] pin_q = '0;
  initial gpio_read = '0;
  always @(posedge clk) begin
    pin_q     <= (gpio_dir & gpio_write) | (~gpio_dir & ext);
    gpio_read <= pin_q;
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [L-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [L-1:0] m_dir, m_wr;
  int m_last;

  task automatic model_reset();
    m_dir  = '0;
    m_wr   = '0;
    m_last = NREQ - 1;
  endtask

  // Applies one command to the model; returns expected response and latency.
  task automatic model_exec(input logic [1:0] op, input logic [L-1:0] mask,
                            input logic [L-1:0] data, output logic [L-1:0] e_data,
                            output logic e_err, output int e_lat);
    e_data = '0;
    e_err  = 1'b0;
    e_lat  = 2;
    for (int b = 0; b < L; b++) begin
      case (op)
        2'd0: begin
          if (mask[b]) m_dir[b] = data[b];
          e_data[b] = m_dir[b];
        end
        2'd1: begin
          if (mask[b]) m_wr[b] = data[b];
          e_data[b] = m_wr[b];
        end
        2'd2: e_data[b] = mask[b] ? (m_dir[b] ? m_wr[b] : ext[b]) : 1'b0;
        default: e_err = 1'b1;
      endcase
    end
    if (op == 2'd2) e_lat = 2 + SETTLE;
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input int k, input logic [1:0] op,
                           input logic [L-1:0] mask, input logic [L-1:0] data);
    req_valid[k]        = 1'b1;
    req_op[2*k +: 2]    = op;
    req_mask[L*k +: L]  = mask;
    req_data[L*k +: L]  = data;
  endtask

  // Waits (bounded) for rsp_valid at negedges; returns cycles since t0.
  task automatic wait_rsp(input int t0, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = rsp_valid ? (cyc - t0) : -1;
  endtask

  // One full command from requester k, starting and ending at a negedge.
  task automatic do_cmd(input string name, input int k, input logic [1:0] op,
                        input logic [L-1:0] mask, input logic [L-1:0] data,
                        input logic [L-1:0] e_data, input logic e_err, input int e_lat);
    int n, t0, lat;
    drive_req(k, op, mask, data);
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, " ready"}, 32'(req_ready), 32'(1 << k));
    t0 = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    m_last = k;
    exp_q.push_back(e_data);
    wait_rsp(t0, lat);
    chk({name, " latency"}, 32'(lat), 32'(e_lat));
    chk({name, " rsp_id"}, 32'(rsp_id), 32'(k));
    chk({name, " rsp_data"}, 32'(rsp_data), 32'(exp_q.pop_front()));
    chk({name, " rsp_err"}, 32'(rsp_err), 32'(e_err));
    chk({name, " busy"}, 32'(busy), 32'd1);
    chk({name, " gpio_dir"}, 32'(gpio_dir), 32'(m_dir));
    chk({name, " gpio_write"}, 32'(gpio_write), 32'(m_wr));
    @(negedge clk);
    chk({name, " pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    int         k;
    logic [1:0] op;
    logic [L-1:0] mask;
    logic [L-1:0] data;
    logic [L-1:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vt[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [L-1:0] e_data;
    logic e_err;
    int e_lat, t0, lat, n, g;

    // Directed vectors starting from reset state with ext pins = 0110.
    vt[0] = '{0, 2'd0, 4'hF,    4'hF,    4'hF,    1'b0};
    vt[1] = '{0, 2'd1, 4'b0101, 4'b1111, 4'b0101, 1'b0};
    vt[2] = '{0, 2'd1, 4'hF,    4'b1010, 4'b1010, 1'b0};
    vt[3] = '{0, 2'd2, 4'hF,    4'h0,    4'b1010, 1'b0};
    vt[4] = '{1, 2'd3, 4'hF,    4'hF,    4'h0,    1'b1};
    vt[5] = '{1, 2'd0, 4'h0,    4'h0,    4'hF,    1'b0};
    vt[6] = '{0, 2'd0, 4'b1100, 4'b0000, 4'b0011, 1'b0};
    vt[7] = '{1, 2'd2, 4'b1110, 4'h0,    4'b0110, 1'b0};
    vt[8] = '{0, 2'd2, 4'b0011, 4'h0,    4'b0010, 1'b0};

    ext       = 4'b0110;
    req_valid = '0;
    req_op    = '0;
    req_mask  = '0;
    req_data  = '0;
    model_reset();

    // Reset with both requesters pending (no-change WRITEs).
    drive_req(0, 2'd1, 4'h0, 4'h0);
    drive_req(1, 2'd1, 4'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset gpio_dir", 32'(gpio_dir), 32'd0);
    chk("reset gpio_write", 32'(gpio_write), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("first grant", 32'(req_ready), 32'd1);
    t0 = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    m_last = 0;
    wait_rsp(t0, lat);
    chk("first latency", 32'(lat), 32'd2);
    chk("first rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);

    // Table-driven directed commands.
    for (int i = 0; i < 9; i++) begin
      model_exec(vt[i].op, vt[i].mask, vt[i].data, e_data, e_err, e_lat);
      do_cmd($sformatf("vec%0d", i), vt[i].k, vt[i].op, vt[i].mask, vt[i].data,
             vt[i].exp_data, vt[i].exp_err, e_lat);
    end

    // Randomized commands against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [L-1:0] mask, data;
      int k;
      k    = $urandom_range(NREQ - 1, 0);
      op   = 2'($urandom_range(3, 0));
      mask = L'($urandom);
      data = L'($urandom);
      ext  = L'($urandom);
      repeat ($urandom_range(2, 0)) @(negedge clk);
      model_exec(op, mask, data, e_data, e_err, e_lat);
      do_cmd($sformatf("rnd%0d", i), k, op, mask, data, e_data, e_err, e_lat);
    end

    // Round-robin: both requesters hold WRITE requests continuously.
    drive_req(0, 2'd1, 4'hF, 4'b0011);
    drive_req(1, 2'd1, 4'hF, 4'b1100);
    for (int i = 0; i < 4; i++) begin
      #1;
      n = 0;
      while (req_ready == '0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      g = (m_last + 1) % NREQ;
      chk($sformatf("rr%0d grant", i), 32'(req_ready), 32'(1 << g));
      t0 = cyc;
      model_exec(2'd1, 4'hF, (g == 0) ? 4'b0011 : 4'b1100, e_data, e_err, e_lat);
      m_last = g;
      @(posedge clk);
      @(negedge clk);
      wait_rsp(t0, lat);
      if (i == 3) req_valid = '0;
      chk($sformatf("rr%0d latency", i), 32'(lat), 32'd2);
      chk($sformatf("rr%0d rsp_id", i), 32'(rsp_id), 32'(g));
      chk($sformatf("rr%0d rsp_data", i), 32'(rsp_data), 32'(e_data));
    end
    @(negedge clk);
    @(negedge clk);

    // Reset during the WAIT of a READ; requester keeps its request up.
    ext = 4'b1001;
    drive_req(0, 2'd2, 4'hF, 4'h0);
    #1;
    chk("rstwait grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstwait busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwait busy clr", 32'(busy), 32'd0);
    chk("rstwait ready", 32'(req_ready), 32'd0);
    chk("rstwait gpio_dir", 32'(gpio_dir), 32'd0);
    chk("rstwait gpio_write", 32'(gpio_write), 32'd0);
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait quiet", 32'(rsp_valid), 32'd0);
    model_exec(2'd2, 4'hF, 4'h0, e_data, e_err, e_lat);
    do_cmd("rstwait regrant", 0, 2'd2, 4'hF, 4'h0, e_data, e_err, e_lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
